// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the two-port to one-port BRAM arbiter.
//   owner_t    : which port owns the read data returning from the BRAM
//   DATA_W     : BRAM word width
//   WMASK_W    : number of byte enables per word
//   STARVE_W   : width of the instruction starvation counter
//   next_owner : response owner to load after a given grant decision
package mem_arb_pkg;

   localparam int DATA_W   = 32;
   localparam int WMASK_W  = 4;
   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Writes return nothing, so only read grants claim the next-cycle data.
   function automatic owner_t next_owner(input logic i_gnt,
                                         input logic d_gnt,
                                         input logic d_we);
      owner_t own;
      own = OWN_NONE;
      if (i_gnt) begin
         own = OWN_I;
      end else if (d_gnt && !d_we) begin
         own = OWN_D;
      end
      return own;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Decides which requester wins the BRAM port this cycle.
// Build option: MEM_ARB_RR_EN
//   undefined : fixed data-over-instruction priority, with a saturating
//               starvation counter that forces an instruction grant once it
//               reaches STARVE_MAX.
//   defined   : round-robin between the two ports using a 1-bit record of
//               the last port granted; STARVE_MAX is ignored.
// Ports:
//   clk      in   clock
//   resetn   in   synchronous active-low reset; grants are held low while asserted
//   i_req_i  in   instruction request
//   d_req_i  in   data request
//   i_gnt_o  out  instruction port wins this cycle
//   d_gnt_o  out  data port wins this cycle (never together with i_gnt_o)
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_req_i,
   input  logic d_req_i,
   output logic i_gnt_o,
   output logic d_gnt_o
);

`ifdef MEM_ARB_RR_EN

   // 0 = instruction granted last, 1 = data granted last.
   logic last_q;
   logic last_d;

   always_comb begin
      i_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
      last_d  = last_q;
      if (resetn) begin
         if (i_req_i && d_req_i) begin
            // On contention the port that did not win last time goes now.
            if (last_q) begin
               i_gnt_o = 1'b1;
            end else begin
               d_gnt_o = 1'b1;
            end
         end else begin
            i_gnt_o = i_req_i;
            d_gnt_o = d_req_i;
         end
      end
      if (i_gnt_o) begin
         last_d = 1'b0;
      end else if (d_gnt_o) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end

`else

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt_q;
   logic [STARVE_W-1:0] starve_cnt_d;
   logic                force_i;

   always_comb begin
      force_i      = i_req_i && (starve_cnt_q == STARVE_LIM);
      i_gnt_o      = 1'b0;
      d_gnt_o      = 1'b0;
      starve_cnt_d = starve_cnt_q;
      if (resetn) begin
         i_gnt_o = i_req_i && (!d_req_i || force_i);
         d_gnt_o = d_req_i && !force_i;
      end
      // Count only consecutive denied cycles; saturate rather than wrap so
      // a forced grant cannot be skipped.
      if (!i_req_i || i_gnt_o) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port BRAM between the instruction-fetch port and the
// load/store port. One access per cycle; read data returns one cycle after
// the grant and is steered by a registered response owner.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration instead of
// fixed data priority with starvation protection (see mem_arb_pick).
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   i_req/i_addr                instruction read request and word address
//   i_gnt/i_rvalid/i_rdata      instruction grant, response valid, data
//   d_req/d_we/d_wmask/d_addr/d_wdata  data request, write flag, byte
//                               enables, word address, write data
//   d_gnt/d_rvalid/d_rdata      data grant, read response valid, data
//   mem_en/mem_we/mem_addr/mem_wdata   BRAM port drive
//   mem_rdata                   BRAM registered read data
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [WMASK_W-1:0]  d_wmask,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_en,
   output logic [WMASK_W-1:0]  mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   owner_t owner_q;
   owner_t owner_d;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk     (clk),
      .resetn  (resetn),
      .i_req_i (i_req),
      .d_req_i (d_req),
      .i_gnt_o (i_gnt),
      .d_gnt_o (d_gnt)
   );

   // BRAM port mux: everything is zero when nobody is granted.
   always_comb begin
      mem_en    = i_gnt | d_gnt;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_addr = d_addr;
         if (d_we) begin
            mem_we    = d_wmask;
            mem_wdata = d_wdata;
         end
      end else if (i_gnt) begin
         mem_addr = i_addr;
      end
   end

   always_comb begin
      owner_d = next_owner(i_gnt, d_gnt, d_we);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Gating with resetn drops a response whose grant was followed
   // immediately by reset, before the owner register has been cleared.
   assign i_rvalid = resetn && (owner_q == OWN_I);
   assign d_rvalid = resetn && (owner_q == OWN_D);
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural BRAM attached.
module tb_mem_arbiter;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              resetn;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_req;
   logic              d_we;
   logic [3:0]        d_wmask;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   logic [31:0] bram [0:255];

   int checks = 0;
   int errors = 0;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_wmask   (d_wmask),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port BRAM, read-first, byte writes.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= bram[mem_addr];
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      resetn = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 8'd5; d_addr = 8'd7;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({i_gnt, d_gnt, mem_en} !== 3'b000 || mem_we !== 4'h0) begin
            errors++;
            $display("FAIL reset_gating cyc %0d got i_gnt=%b d_gnt=%b mem_en=%b mem_we=%h exp all 0",
                     k, i_gnt, d_gnt, mem_en, mem_we);
         end
      end
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({i_rvalid, d_rvalid, i_gnt, d_gnt} !== 4'b0001 || mem_addr !== 8'd7) begin
         errors++;
         $display("FAIL reset_release got i_rv=%b d_rv=%b i_gnt=%b d_gnt=%b addr=%0d exp 0 0 0 1 addr=7",
                  i_rvalid, d_rvalid, i_gnt, d_gnt, mem_addr);
      end
      @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'h1000_0007) begin
         errors++;
         $display("FAIL reset_first_read got d_rv=%b i_rv=%b d_rdata=%h exp 1 0 10000007",
                  d_rvalid, i_rvalid, d_rdata);
      end
   endtask

   task automatic test_fetch;
      @(posedge clk); #1 i_req = 1'b1; i_addr = 8'd5;
      @(negedge clk);
      checks++;
      if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'd5 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL fetch_grant got i_gnt=%b d_gnt=%b en=%b addr=%0d we=%h exp 1 0 1 5 0",
                  i_gnt, d_gnt, mem_en, mem_addr, mem_we);
      end
      @(posedge clk); #1 i_req = 1'b0;
      @(negedge clk);
      checks++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'h0000_A103) begin
         errors++;
         $display("FAIL fetch_data got i_rv=%b d_rv=%b i_rdata=%h exp 1 0 0000a103",
                  i_rvalid, d_rvalid, i_rdata);
      end
   endtask

   task automatic test_contention;
      int  prev;
      logic exp_i;
      prev = 0;
      @(posedge clk); #1 i_req = 1'b1; i_addr = 8'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 8'd9;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
`ifdef MEM_ARB_RR_EN
         exp_i = (k % 2) == 1;
`else
         exp_i = (k == 4) || (k == 9);
`endif
         checks++;
         if (i_gnt !== exp_i || d_gnt !== !exp_i || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL contention_grant cyc %0d got i_gnt=%b d_gnt=%b en=%b exp i_gnt=%b d_gnt=%b en=1",
                     k, i_gnt, d_gnt, mem_en, exp_i, !exp_i);
         end
         checks++;
         if (i_rvalid !== (prev == 1) || d_rvalid !== (prev == 2) ||
             (prev == 1 && i_rdata !== 32'h0000_A103) || (prev == 2 && d_rdata !== 32'h1000_0009)) begin
            errors++;
            $display("FAIL contention_resp cyc %0d got i_rv=%b d_rv=%b data=%h prev_owner=%0d",
                     k, i_rvalid, d_rvalid, i_rdata, prev);
         end
         prev = exp_i ? 1 : 2;
         @(posedge clk);
      end
      #1 i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || i_rvalid !== (prev == 1) || d_rvalid !== (prev == 2)) begin
         errors++;
         $display("FAIL contention_tail got en=%b i_rv=%b d_rv=%b prev_owner=%0d", mem_en, i_rvalid, d_rvalid, prev);
      end
   endtask

`ifndef MEM_ARB_RR_EN
   // A low cycle on i_req must clear the partial starvation count.
   task automatic test_starve_clear;
      logic [7:0] ireq_pat;
      logic [7:0] igMT_pat;
      ireq_pat = 8'b1111_1011;
      igMT_pat = 8'b1000_0000;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1 i_req = ireq_pat[k]; d_req = 1'b1; d_we = 1'b0;
         @(negedge clk);
         checks++;
         if (i_gnt !== igMT_pat[k] || d_gnt !== !igMT_pat[k]) begin
            errors++;
            $display("FAIL starve_clear cyc %0d got i_gnt=%b d_gnt=%b exp i_gnt=%b",
                     k, i_gnt, d_gnt, igMT_pat[k]);
         end
      end
      @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
   endtask
`endif

   task automatic test_byte_write;
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 8'd3; d_wmask = 4'b0010; d_wdata = 32'h0000_AB00;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || mem_addr !== 8'd3 || mem_we !== 4'b0010 || mem_wdata !== 32'h0000_AB00) begin
         errors++;
         $display("FAIL byte_write_port got gnt=%b addr=%0d we=%b wdata=%h exp 1 3 0010 0000ab00",
                  d_gnt, mem_addr, mem_we, mem_wdata);
      end
      @(posedge clk); #1 d_we = 1'b0;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || d_rvalid !== 1'b0 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL byte_write_norv got gnt=%b d_rv=%b we=%h exp 1 0 0", d_gnt, d_rvalid, mem_we);
      end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122_AB44) begin
         errors++;
         $display("FAIL byte_write_readback got d_rv=%b d_rdata=%h exp 1 1122ab44", d_rvalid, d_rdata);
      end
   endtask

   task automatic test_zero_mask;
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 8'd5; d_wmask = 4'b0000; d_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL zero_mask_grant got gnt=%b en=%b we=%h exp 1 1 0", d_gnt, mem_en, mem_we);
      end
      @(posedge clk); #1 d_we = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL zero_mask_norv got d_rv=%b exp 0", d_rvalid);
      end
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_A103) begin
         errors++;
         $display("FAIL zero_mask_unchanged got d_rv=%b d_rdata=%h exp 1 0000a103", d_rvalid, d_rdata);
      end
   endtask

   task automatic test_reset_mid_read;
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 8'd3;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midrst_grant got d_gnt=%b exp 1", d_gnt);
      end
      @(posedge clk); #1 resetn = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL midrst_n1 got d_rv=%b d_gnt=%b en=%b exp 0 0 0", d_rvalid, d_gnt, mem_en);
      end
      @(posedge clk); #1 resetn = 1'b1; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0 ||
          mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL midrst_n2_idle got d_rv=%b i_rv=%b en=%b we=%h addr=%0d wdata=%h exp all 0",
                  d_rvalid, i_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) bram[a] = 32'h1000_0000 + a;
      bram[5] = 32'h0000_A103;
      bram[3] = 32'h1122_3344;
      mem_rdata = 32'd0;
      resetn = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0; d_addr = '0; d_wdata = 32'd0;

      test_reset();
      test_fetch();
      test_contention();
`ifndef MEM_ARB_RR_EN
      test_starve_clear();
`endif
      test_byte_write();
      test_zero_mask();
      test_reset_mid_read();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port arbiter that shares the single-port 32-bit BRAM between the core's instruction-fetch port and its load/store port. Sits between the fetch/execute logic and the `MEM` array and replaces direct `MEM[PC]` indexing. Each cycle it grants at most one requester, drives the BRAM port and routes the read data back one cycle later. Starvation protection guarantees forward progress for instruction fetch.

## Interface
Parameters:
- ADDR_W, 8, word-address width (256 words)
- STARVE_MAX, 4, number of consecutive cycles an instruction request may be denied before it is forced through (range 1–15)

Ports:
- clk  in  1  system clock (divided clock from clk_divider)
- resetn  in  1  reset; synchronous, active-low
- i_req  in  1  instruction read request; held high until granted
- i_addr  in  ADDR_W  instruction word address; stable while i_req is high
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  32  instruction read data
- d_req  in  1  data request; held high until granted
- d_we  in  1  1 = write, 0 = read
- d_wmask  in  4  byte enables for writes; bit n enables byte n
- d_addr  in  ADDR_W  data word address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (reads only)
- d_rdata  out  32  data read data
- mem_en  out  1  BRAM access enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM registered read data; valid one cycle after mem_en

## Operation
- Grant is combinational from the requests and registered arbiter state. At most one of i_gnt and d_gnt is high in any cycle.
- Default priority is fixed, data over instruction.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each cycle that i_req is high and i_gnt is low.
  - Clears on i_gnt, or whenever i_req is low.
  - When starve_cnt == STARVE_MAX and i_req is high, the instruction port wins even if d_req is high.
- On a grant, the winner's address is placed on mem_addr and mem_en=1.
  - Data write: mem_we = d_wmask, mem_wdata = d_wdata.
  - Any read: mem_we = 0.
- When no port is granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Response-owner register `owner` (OWN_NONE / OWN_I / OWN_D) is loaded at each clock edge:
  - OWN_I after an instruction grant.
  - OWN_D after a data read grant.
  - OWN_NONE after a data write or an idle cycle.
- Response outputs: i_rvalid = (owner == OWN_I) and d_rvalid = (owner == OWN_D). i_rdata and d_rdata both drive mem_rdata continuously; they are meaningful only when the matching rvalid is high.
- Writes complete at the edge that ends their grant cycle and produce no rvalid.
- No forwarding is performed. A read granted in the cycle after a write to the same address returns the new data, because the BRAM write has already taken effect.
- d_wmask == 0 with d_we=1 is still granted. It produces an enable-only cycle with no bytes written.

## Timing
- Reset (resetn low at a clk edge):
  - owner = OWN_NONE, starve_cnt = 0.
  - While resetn is low, i_gnt, d_gnt, mem_en and mem_we are forced to 0.
  - After reset: i_rvalid = d_rvalid = 0.
- Read latency: grant in cycle N gives rvalid in cycle N+1. Fully pipelined, so one access per cycle with back-to-back grants allowed. Throughput is one access per cycle total.
- Handshake:
  - A requester holds req, addr and wdata until it sees gnt.
  - It may deassert req in the cycle after gnt.
  - If req stays high after gnt, that is a new request.
- Simultaneous i_req and d_req: d wins unless starve_cnt == STARVE_MAX.
- Reset asserted in the cycle after a read grant: the pending rvalid is dropped.
- starve_cnt saturates at STARVE_MAX; it never wraps.

## Configuration
- MEM_ARB_RR_EN
  - Defined: round-robin arbitration. A 1-bit `last` register records the last port granted (reset 0 = instruction). On contention the port not granted last wins. starve_cnt and STARVE_MAX are not used and STARVE_MAX is ignored.
  - Undefined: fixed data priority with starvation counter, as described above.

## Structure
- Package `mem_arb_pkg`: owner_t enum (OWN_NONE, OWN_I, OWN_D), and the constants DATA_W = 32 and WMASK_W = 4.
- One sub-module, `mem_arb_pick`. It holds the priority/starvation state (or the round-robin `last` register under MEM_ARB_RR_EN) and outputs the winner. The top level holds `owner` and the BRAM port muxing.

## Test plan
- Reset: hold resetn low with i_req=d_req=1. Required: i_gnt=d_gnt=mem_en=0 throughout. One cycle after release: i_rvalid=d_rvalid=0 and d_gnt=1.
- Single fetch: i_req=1 with i_addr=5, where MEM[5]=0x0000A103. Required: i_gnt=1 and mem_addr=5 in cycle N; i_rvalid=1 and i_rdata=0x0000A103 in N+1.
- Contention, default build with STARVE_MAX=4: hold i_req and d_req high with d_req re-asserted each cycle. Required: grants d,d,d,d,i,d,d,d,d,i,…
- Byte write then read: d_we=1, d_addr=3, d_wmask=4'b0010, d_wdata=0x0000AB00, over a prior 0x11223344; next cycle d read at 3. Required: d_rvalid=1 and d_rdata=0x1122AB44 two cycles after the write grant.
- Round robin (MEM_ARB_RR_EN): both ports requesting continuously from reset. Required: grants d,i,d,i,… with no gaps in mem_en.
- Reset mid-read: d read granted in cycle N, resetn low in N+1. Required: d_rvalid=0 in N+1 and N+2.
